maf_t3_align_csa_stage: RTL and testbench
=========================================

// Module: maf_t3_align_csa_stage
// PURPOSE
//  Parametrised successor of the MAF third-stage front half.
//  - Aligns the addend with a saturating right shift and produces sticky bits, in one full-width lane or two independent half lanes.
//  - Applies conditional bit-inversion (effective subtract).
//  - Compresses NUM_ROWS partial-product rows by one 3:2 CSA level.
//  - Registers data plus sideband behind a valid/ready handshake with flush and trap-gating.
//  - Sits between the T2 exponent/shift-count stage and the T3 second-half adder.
// PARAMETERS
//  ROW_W     96  width of one partial-product row
//  NUM_ROWS  6   input rows; must be a multiple of 3; output rows = 2*NUM_ROWS/3
//  ADD_W     76  addend width; must be even (half lane = ADD_W/2)
//  SH_W      12  width of one shift count
//  SB_W      32  sideband width (trap, trap_ans, signs, cont, d, E packed by caller)
//  CNT_W     16  stall counter width
// PORTS
//  clk        in   1                     clock, rising edge
//  rst        in   1                     asynchronous reset, active-high
//  mode       in   1                     0 = one ADD_W lane, 1 = two ADD_W/2 lanes
//  flush      in   1                     synchronous kill of the registered beat
//  in_valid   in   1                     input beat valid
//  in_ready   out  1                     stage can accept a beat
//  rows_in    in   NUM_ROWS*ROW_W        partial-product rows; row k at [k*ROW_W +: ROW_W]
//  add_in     in   ADD_W                 addend significand
//  sh_num     in   2*SH_W                lane0 count [SH_W-1:0]; lane1 count [2*SH_W-1:SH_W]
//  eff_sub    in   2                     per-lane invert request; lane0 = bit0
//  trap_in    in   1                     special operand; data path is gated
//  sb_in      in   SB_W                  sideband, passed through unmodified
//  out_valid  out  1                     output beat valid
//  out_ready  in   1                     downstream accepts
//  rows_out   out  (2*NUM_ROWS/3)*ROW_W  per group g: sum at row 2g, carry at row 2g+1
//  add_out    out  ADD_W                 aligned and optionally inverted addend
//  sti        out  2                     per-lane sticky; in mode 0 only bit0 is used, bit1 = 0
//  trap_out   out  1                     registered trap_in
//  sb_out     out  SB_W                  registered sb_in
//  stall_cnt  out  CNT_W                 saturating count of stall cycles
// BEHAVIOUR
//  Reset (rst=1, async) forces:
//   - out_valid=0, trap_out=0, stall_cnt=0.
//   - rows_out, add_out, sti and sb_out all zero.
//  Handshake:
//   - in_ready = !out_valid | out_ready (combinational, no skid).
//   - accept = in_valid & in_ready.
//   - Latency is exactly 1 cycle: accepted beat appears on the next edge.
//   - Output holds stable while out_valid & !out_ready.
//  Register update on each edge:
//   - flush=1: out_valid<=0; data registers hold; flush wins over a simultaneous accept (beat dropped).
//   - else if accept: out_valid<=1 and all output registers load.
//   - else if out_ready: out_valid<=0.
//  Trap gating:
//   - On accept with trap_in=1: rows_out, add_out and sti hold their previous values (power save).
//   - trap_out, sb_out and out_valid still update.
//  CSA, per group g of rows a,b,c (rows 3g, 3g+1, 3g+2):
//   - sum = a^b^c.
//   - carry = ((a&b)|(a&c)|(b&c)) << 1, truncated to ROW_W; the MSB carry is discarded.
//  Alignment, lane of width L shifted by count s:
//   - Mode 0: L=ADD_W, s=sh_num[SH_W-1:0].
//   - Mode 1: lane0 = add_in[L-1:0], lane1 = add_in[ADD_W-1:L], L=ADD_W/2.
//   - s < L: aligned = lane >> s; sticky = OR of the s shifted-out bits.
//   - s >= L (saturation): aligned = 0; sticky = OR of the whole lane.
//   - s = 0: aligned = lane; sticky = 0.
//   - eff_sub bit set: add_out lane = ~aligned. Sticky is computed before inversion and is not inverted.
//   - Mode 0 uses eff_sub[0] only.
//  Stall counter:
//   - Increments on every cycle with out_valid & !out_ready.
//   - Saturates at 2^CNT_W-1; flush does not clear it.
//  mode is sampled with the beat on accept; mode changes between beats need no bubble.
// TESTING
//  1 Reset mid-beat: out_valid=1, assert rst -> every output 0 immediately (before the next clk); in_ready=1.
//  2 CSA (ROW_W=96): rows 0,1,2 = 0x7, 0x5, 0x3 -> sum=0x1, carry=0xE; all rows 0xFF..F -> carry MSB dropped.
//  3 Mode 0 alignment: add_in=0x1<<10, s=11 -> add_out=0, sti=01.
//    - Same add_in, s=200 (saturation) -> add_out=0, sti=01.
//    - add_in=0x3, s=1 -> add_out=0x1, sti=01.
//  4 Mode 1 alignment: lane1=0x8000..0, s1=4; lane0=0x5, s0=0; eff_sub=01.
//    - lane1 -> 0x0800..0, sti[1]=0.
//    - lane0 -> ~0x5 in 38 bits, sti[0]=0.
//  5 Backpressure: 3 back-to-back beats with out_ready low for 4 cycles.
//    - in_ready=0 while stalled; no beat lost or duplicated; beats emerge in order.
//    - stall_cnt=4.
//  6 Flush plus accept in the same cycle -> out_valid=0 next cycle.
//    Trap beat -> rows_out/add_out unchanged, sb_out updated, trap_out=1.

Source files
------------

// File: rtl/maf_t3_align_csa_stage.sv
// MAF third-stage front half: addend alignment with sticky, effective-subtract
// inversion and one 3:2 CSA level, registered behind a valid/ready handshake.
module maf_t3_align_csa_stage #(
  parameter int ROW_W    = 96,
  parameter int NUM_ROWS = 6,
  parameter int ADD_W    = 76,
  parameter int SH_W     = 12,
  parameter int SB_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                mode,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_ROWS*ROW_W-1:0]           rows_in,
  input  logic [ADD_W-1:0]                    add_in,
  input  logic [2*SH_W-1:0]                   sh_num,
  input  logic [1:0]                          eff_sub,
  input  logic                                trap_in,
  input  logic [SB_W-1:0]                     sb_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [(2*NUM_ROWS/3)*ROW_W-1:0]     rows_out,
  output logic [ADD_W-1:0]                    add_out,
  output logic [1:0]                          sti,
  output logic                                trap_out,
  output logic [SB_W-1:0]                     sb_out,
  output logic [CNT_W-1:0]                    stall_cnt
);

  localparam int GROUPS   = NUM_ROWS / 3;
  localparam int OUT_ROWS = 2 * GROUPS;
  localparam int HALF     = ADD_W / 2;
  localparam logic [SH_W-1:0] FULL_LEN = SH_W'(ADD_W);
  localparam logic [SH_W-1:0] HALF_LEN = SH_W'(HALF);

  logic [OUT_ROWS*ROW_W-1:0] csa_rows;
  logic [ADD_W-1:0]          add_next;
  logic [1:0]                sti_next;
  logic                      accept;

  // Returns {sticky, aligned}; counts at or beyond the lane width saturate.
  function automatic logic [ADD_W:0] align_full(input logic [ADD_W-1:0] lane,
                                                input logic [SH_W-1:0]  s);
    logic [ADD_W-1:0] aligned;
    logic [ADD_W-1:0] mask;
    if (s >= FULL_LEN) begin
      aligned = '0;
      mask    = '1;
    end else begin
      aligned = lane >> s;
      mask    = ~({ADD_W{1'b1}} << s);
    end
    return {|(lane & mask), aligned};
  endfunction

  function automatic logic [HALF:0] align_half(input logic [HALF-1:0] lane,
                                               input logic [SH_W-1:0] s);
    logic [HALF-1:0] aligned;
    logic [HALF-1:0] mask;
    if (s >= HALF_LEN) begin
      aligned = '0;
      mask    = '1;
    end else begin
      aligned = lane >> s;
      mask    = ~({HALF{1'b1}} << s);
    end
    return {|(lane & mask), aligned};
  endfunction

  for (genvar g = 0; g < GROUPS; g++) begin : g_csa
    logic [ROW_W-1:0] a, b, c, maj;
    assign a   = rows_in[(3*g)*ROW_W   +: ROW_W];
    assign b   = rows_in[(3*g+1)*ROW_W +: ROW_W];
    assign c   = rows_in[(3*g+2)*ROW_W +: ROW_W];
    assign maj = (a & b) | (a & c) | (b & c);
    assign csa_rows[(2*g)*ROW_W   +: ROW_W] = a ^ b ^ c;
    assign csa_rows[(2*g+1)*ROW_W +: ROW_W] = {maj[ROW_W-2:0], 1'b0};
  end

  // Sticky is taken from the un-inverted aligned lane.
  always_comb begin
    logic [ADD_W:0] full_res;
    logic [HALF:0]  lo_res;
    logic [HALF:0]  hi_res;
    full_res = align_full(add_in, sh_num[SH_W-1:0]);
    lo_res   = align_half(add_in[HALF-1:0], sh_num[SH_W-1:0]);
    hi_res   = align_half(add_in[ADD_W-1:HALF], sh_num[2*SH_W-1:SH_W]);
    add_next = '0;
    sti_next = '0;
    if (mode) begin
      add_next = {hi_res[HALF-1:0] ^ {HALF{eff_sub[1]}},
                  lo_res[HALF-1:0] ^ {HALF{eff_sub[0]}}};
      sti_next = {hi_res[HALF], lo_res[HALF]};
    end else begin
      add_next = full_res[ADD_W-1:0] ^ {ADD_W{eff_sub[0]}};
      sti_next = {1'b0, full_res[ADD_W]};
    end
  end

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Flush drops any simultaneous beat; trap beats leave the datapath registers untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rows_out  <= '0;
      add_out   <= '0;
      sti       <= '0;
      trap_out  <= 1'b0;
      sb_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      trap_out  <= trap_in;
      sb_out    <= sb_in;
      if (!trap_in) begin
        rows_out <= csa_rows;
        add_out  <= add_next;
        sti      <= sti_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_maf_t3_align_csa_stage.sv
// Directed, table-driven bench for maf_t3_align_csa_stage with hand-computed
// expectations plus sequences for reset, backpressure, flush and trap gating.
module tb_maf_t3_align_csa_stage;

  typedef struct {
    logic         mode;
    logic [575:0] rows;
    logic [75:0]  add;
    logic [23:0]  sh;
    logic [1:0]   eff;
    logic [383:0] exp_rows;
    logic [75:0]  exp_add;
    logic [1:0]   exp_sti;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [575:0] rows_in = '0;
  logic [75:0]  add_in = '0;
  logic [23:0]  sh_num = '0;
  logic [1:0]   eff_sub = '0;
  logic         trap_in = 1'b0;
  logic [31:0]  sb_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [383:0] rows_out;
  logic [75:0]  add_out;
  logic [1:0]   sti;
  logic         trap_out;
  logic [31:0]  sb_out;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int failures = 0;
  vec_t vecs[12];

  maf_t3_align_csa_stage dut (
    .clk(clk), .rst(rst), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rows_in(rows_in), .add_in(add_in), .sh_num(sh_num), .eff_sub(eff_sub),
    .trap_in(trap_in), .sb_in(sb_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rows_out(rows_out), .add_out(add_out), .sti(sti),
    .trap_out(trap_out), .sb_out(sb_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [511:0] act,
                             input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one beat at a falling edge and returns at the following falling edge.
  task automatic applyStimulus(input vec_t v, input logic [31:0] sb, input logic trap);
    mode     = v.mode;
    rows_in  = v.rows;
    add_in   = v.add;
    sh_num   = v.sh;
    eff_sub  = v.eff;
    trap_in  = trap;
    sb_in    = sb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    trap_in  = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input vec_t v, input logic [31:0] sb);
    checkOutput({tag, "_valid"}, 512'(out_valid), 512'(1'b1));
    checkOutput({tag, "_rows"},  512'(rows_out), 512'(v.exp_rows));
    checkOutput({tag, "_add"},   512'(add_out), 512'(v.exp_add));
    checkOutput({tag, "_sti"},   512'(sti), 512'(v.exp_sti));
    checkOutput({tag, "_sb"},    512'(sb_out), 512'(sb));
    checkOutput({tag, "_trap"},  512'(trap_out), 512'(1'b0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 512'(out_valid), 512'(0));
    checkOutput({tag, "_rows"},  512'(rows_out), 512'(0));
    checkOutput({tag, "_add"},   512'(add_out), 512'(0));
    checkOutput({tag, "_sti"},   512'(sti), 512'(0));
    checkOutput({tag, "_trap"},  512'(trap_out), 512'(0));
    checkOutput({tag, "_sb"},    512'(sb_out), 512'(0));
    checkOutput({tag, "_stall"}, 512'(stall_cnt), 512'(0));
    checkOutput({tag, "_in_ready"}, 512'(in_ready), 512'(1'b1));
  endtask

  initial begin
    logic [95:0] ones96;
    logic [95:0] carry96;
    logic [75:0] bp_add[3];
    logic [31:0] bp_sb[3];
    vec_t pre;
    int sent;
    int got;

    ones96  = '1;
    carry96 = {{95{1'b1}}, 1'b0};
    for (int i = 0; i < 12; i++) begin
      vecs[i].mode = 1'b0; vecs[i].rows = '0; vecs[i].add = '0; vecs[i].sh = '0;
      vecs[i].eff = 2'b00; vecs[i].exp_rows = '0; vecs[i].exp_add = '0; vecs[i].exp_sti = 2'b00;
    end
    // CSA small rows
    vecs[0].rows[0+:96] = 96'h7; vecs[0].rows[96+:96] = 96'h5; vecs[0].rows[192+:96] = 96'h3;
    vecs[0].exp_rows[0+:96] = 96'h1; vecs[0].exp_rows[96+:96] = 96'hE;
    // CSA all ones: carry MSB dropped
    vecs[1].rows = '1;
    vecs[1].exp_rows = {carry96, ones96, carry96, ones96};
    // Mode 0: single bit shifted out
    vecs[2].add = 76'h400; vecs[2].sh = {12'd0, 12'd11}; vecs[2].exp_sti = 2'b01;
    vecs[2].rows[288+:96] = 96'hF0; vecs[2].rows[384+:96] = 96'hCC; vecs[2].rows[480+:96] = 96'hAA;
    vecs[2].exp_rows[192+:96] = 96'h96; vecs[2].exp_rows[288+:96] = 96'h1D0;
    // Mode 0 saturation
    vecs[3].add = 76'h400; vecs[3].sh = {12'd0, 12'd200}; vecs[3].exp_sti = 2'b01;
    // Mode 0 small shift
    vecs[4].add = 76'h3; vecs[4].sh = {12'd0, 12'd1}; vecs[4].exp_add = 76'h1; vecs[4].exp_sti = 2'b01;
    // Mode 1 split lanes, lane0 inverted
    vecs[5].mode = 1'b1; vecs[5].add = {38'h20_0000_0000, 38'h5}; vecs[5].sh = {12'd4, 12'd0};
    vecs[5].eff = 2'b01; vecs[5].exp_add = {38'h02_0000_0000, 38'h3F_FFFF_FFFA};
    // Mode 0 inverted, exact shift with no sticky
    vecs[6].add = 76'hF0; vecs[6].sh = {12'd0, 12'd4}; vecs[6].eff = 2'b01;
    vecs[6].exp_add = ~76'hF;
    // Mode 1 lane0 saturates at exactly L, lane1 inverted
    vecs[7].mode = 1'b1; vecs[7].add = {38'd0, 38'd1}; vecs[7].sh = {12'd0, 12'd38};
    vecs[7].eff = 2'b10; vecs[7].exp_add = {38'h3F_FFFF_FFFF, 38'd0}; vecs[7].exp_sti = 2'b01;
    // Mode 1 lane0 at L-1, lane1 sticky
    vecs[8].mode = 1'b1; vecs[8].add = {38'd3, 38'h20_0000_0000}; vecs[8].sh = {12'd1, 12'd37};
    vecs[8].exp_add = {38'd1, 38'd1}; vecs[8].exp_sti = 2'b10;
    // Mode 0 at ADD_W-1, lane1 count ignored
    vecs[9].add = {1'b1, 75'd0}; vecs[9].sh = {12'd5, 12'd75}; vecs[9].exp_add = 76'h1;
    // Mode 0 at exactly ADD_W
    vecs[10].add = {1'b1, 75'd0}; vecs[10].sh = {12'd0, 12'd76}; vecs[10].exp_sti = 2'b01;
    // Mode 0 ignores eff_sub[1]
    vecs[11].add = {1'b1, 75'd0}; vecs[11].eff = 2'b10; vecs[11].exp_add = {1'b1, 75'd0};

    // Reset state
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Reset while a beat is held on the output
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(vecs[1], 32'hDEAD_BEEF, 1'b0);
    checkOutput("midbeat_loaded", 512'(out_valid), 512'(1'b1));
    #2 rst = 1'b1;
    #1 checkAllZero("midbeat_reset");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // Vector table, one beat each with downstream always ready
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], 32'hA000_0000 + 32'(i), 1'b0);
      checkBeat($sformatf("vec%0d", i), vecs[i], 32'hA000_0000 + 32'(i));
    end

    // Backpressure: three beats, downstream stalled for four cycles
    repeat (2) @(negedge clk);
    mode = 1'b0; sh_num = '0; eff_sub = '0; rows_in = '0;
    bp_add[0] = 76'h123; bp_add[1] = 76'h456; bp_add[2] = 76'h789;
    bp_sb[0] = 32'h0B0; bp_sb[1] = 32'h0B1; bp_sb[2] = 32'h0B2;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 3);
      if (sent < 3) begin
        add_in = bp_add[sent];
        sb_in  = bp_sb[sent];
      end
      #1;
      if (cyc >= 1 && cyc <= 4) begin
        checkOutput($sformatf("bp_in_ready_c%0d", cyc), 512'(in_ready), 512'(1'b0));
        checkOutput($sformatf("bp_hold_c%0d", cyc), 512'(sb_out), 512'(bp_sb[0]));
      end
      if (out_valid && out_ready) begin
        if (got < 3) begin
          checkOutput($sformatf("bp_sb_%0d", got), 512'(sb_out), 512'(bp_sb[got]));
          checkOutput($sformatf("bp_add_%0d", got), 512'(add_out), 512'(bp_add[got]));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checkOutput("bp_sent", 512'(sent), 512'(3));
    checkOutput("bp_got", 512'(got), 512'(3));
    checkOutput("bp_stall_cnt", 512'(stall_cnt), 512'(4));

    // Flush together with an accept drops the beat
    @(negedge clk);
    out_ready = 1'b1;
    add_in = 76'hABC; sb_in = 32'h55; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_valid", 512'(out_valid), 512'(1'b0));
    checkOutput("flush_add_hold", 512'(add_out), 512'(bp_add[2]));
    checkOutput("flush_sb_hold", 512'(sb_out), 512'(bp_sb[2]));

    // Trap beat leaves the datapath outputs at the previous beat's values
    pre = vecs[0];
    pre.add = 76'h3; pre.sh = {12'd0, 12'd1}; pre.exp_add = 76'h1; pre.exp_sti = 2'b01;
    applyStimulus(pre, 32'h11, 1'b0);
    checkBeat("pretrap", pre, 32'h11);
    applyStimulus(vecs[1], 32'h22, 1'b1);
    checkOutput("trap_valid", 512'(out_valid), 512'(1'b1));
    checkOutput("trap_out", 512'(trap_out), 512'(1'b1));
    checkOutput("trap_sb", 512'(sb_out), 512'(32'h22));
    checkOutput("trap_rows_hold", 512'(rows_out), 512'(pre.exp_rows));
    checkOutput("trap_add_hold", 512'(add_out), 512'(pre.exp_add));
    checkOutput("trap_sti_hold", 512'(sti), 512'(pre.exp_sti));
    applyStimulus(vecs[1], 32'h33, 1'b0);
    checkBeat("posttrap", vecs[1], 32'h33);

    // Flush must not have cleared the stall counter
    checkOutput("stall_cnt_kept", 512'(stall_cnt), 512'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
